seg_scan_ctrl: RTL and testbench

Scan scheduler for the 4-digit multiplexed common-cathode 7-segment display. It time-shares the single segment decoder across four digits, one digit per time slot. Each slot has a dead-time phase with all commons off, to prevent ghosting, followed by a PWM brightness-controlled on-phase. New display values are accepted through a req/ack handshake and take effect only at frame boundaries, so a frame never tears. Sits between the value producer (counter, timer) and the top-level hex decoder and pin inversion.

---
 rtl/seg_scan_ctrl.sv | 103 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scan scheduler for a 4-digit multiplexed common-cathode
// 7-segment display. Each digit slot opens with a dead time (all commons off)
// and then runs a 16-step PWM on-phase. New values and brightness settings
// are taken only at the frame boundary, so a frame is never torn.
module seg_scan_ctrl #(
  parameter int          SLOT_CYCLES = 3000,
  parameter int          DEAD_CYCLES = 64,
  parameter logic [15:0] INIT_VALUE  = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA_IN,
  input  logic        LOAD_REQ,
  output logic        LOAD_ACK,
  input  logic [3:0]  BRIGHT,
  input  logic        BLANK_LZ,
  output logic [3:0]  COMM,
  output logic [1:0]  DIGIT_SEL,
  output logic [3:0]  NIBBLE,
  output logic        FRAME_START
);

  // At least 4 counter bits so the PWM phase can be taken from the low nibble.
  localparam int CW_RAW = $clog2(SLOT_CYCLES);
  localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] DEAD_LEN  = CW'(DEAD_CYCLES);
  localparam logic [3:0]    DEAD_MOD  = 4'(DEAD_CYCLES % 16);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  logic [15:0]   disp;
  logic [3:0]    bright_l;
  logic          blz_l;
  logic          load_ack_q;

  logic          slot_end;
  logic          frame_end;
  logic          in_dead;
  logic [3:0]    pwm_phase;
  logic          pwm_on;
  logic          blanked;

  assign slot_end  = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_end && (digit_idx == 2'd3);

  // Slot/digit scan counters and frame-boundary capture of display settings.
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt   <= '0;
      digit_idx  <= 2'd0;
      disp       <= INIT_VALUE;
      bright_l   <= 4'hF;
      blz_l      <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      slot_cnt   <= slot_end ? '0 : slot_cnt + 1'b1;
      load_ack_q <= frame_end && LOAD_REQ;
      if (slot_end) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (frame_end) begin
        bright_l <= BRIGHT;
        blz_l    <= BLANK_LZ;
        if (LOAD_REQ) begin
          disp <= DATA_IN;
        end
      end
    end
  end

  // (c - DEAD) mod 16 only depends on the low nibbles of both operands.
  assign in_dead   = (slot_cnt < DEAD_LEN);
  assign pwm_phase = slot_cnt[3:0] - DEAD_MOD;
  assign pwm_on    = (pwm_phase <= bright_l);

  // Leading-zero suppression; digit0 always shows so a zero value reads "0".
  always_comb begin
    blanked = 1'b0;
    if (blz_l) begin
      case (digit_idx)
        2'd3:    blanked = (disp[15:12] == 4'h0);
        2'd2:    blanked = (disp[15:8] == 8'h00);
        2'd1:    blanked = (disp[15:4] == 12'h000);
        default: blanked = 1'b0;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    COMM        = 4'b0000;
    DIGIT_SEL   = digit_idx;
    NIBBLE      = disp[{digit_idx, 2'b00} +: 4];
    FRAME_START = (digit_idx == 2'd0) && (slot_cnt == '0);
    LOAD_ACK    = load_ack_q;
    if (!in_dead && pwm_on && !blanked) begin
      COMM = 4'b0001 << digit_idx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a short slot (40 clocks, 8 dead) so several
// frames fit in a short run. A behavioural model predicts every output cycle;
// targeted checks pin down the cycle numbers of the scan timing.
module tb_seg_scan_ctrl;

  localparam int          SLOT = 40;
  localparam int          DEAD = 8;
  localparam logic [15:0] INIT = 16'h1234;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] DATA_IN = 16'h0000;
  logic        LOAD_REQ = 1'b0;
  logic        LOAD_ACK;
  logic [3:0]  BRIGHT = 4'hF;
  logic        BLANK_LZ = 1'b0;
  logic [3:0]  COMM;
  logic [1:0]  DIGIT_SEL;
  logic [3:0]  NIBBLE;
  logic        FRAME_START;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;

  // reference model state
  int          m_c;
  int          m_d;
  logic [15:0] m_disp;
  logic [3:0]  m_bright;
  logic        m_blz;
  logic        m_ack;

  logic [11:0] exp_q[$];

  seg_scan_ctrl #(
    .SLOT_CYCLES(SLOT),
    .DEAD_CYCLES(DEAD),
    .INIT_VALUE (INIT)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .DATA_IN    (DATA_IN),
    .LOAD_REQ   (LOAD_REQ),
    .LOAD_ACK   (LOAD_ACK),
    .BRIGHT     (BRIGHT),
    .BLANK_LZ   (BLANK_LZ),
    .COMM       (COMM),
    .DIGIT_SEL  (DIGIT_SEL),
    .NIBBLE     (NIBBLE),
    .FRAME_START(FRAME_START)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_out();
    logic       blank;
    logic       lit;
    logic [3:0] nib;
    logic [3:0] comm;
    blank = m_blz && ((m_d == 3 && m_disp[15:12] == 4'h0) ||
                      (m_d == 2 && m_disp[15:8] == 8'h00) ||
                      (m_d == 1 && m_disp[15:4] == 12'h000));
    nib   = 4'((m_disp >> (4 * m_d)) & 16'h000F);
    lit   = (m_c >= DEAD) && (((m_c - DEAD) % 16) <= int'(m_bright)) && !blank;
    comm  = lit ? 4'(1 << m_d) : 4'h0;
    return {comm, 2'(m_d), nib, (m_d == 0 && m_c == 0), m_ack};
  endfunction

  task automatic model_step();
    logic boundary;
    if (RST) begin
      m_c = 0; m_d = 0; m_disp = INIT; m_bright = 4'hF; m_blz = 1'b0; m_ack = 1'b0;
    end else begin
      boundary = (m_d == 3) && (m_c == SLOT - 1);
      m_ack = boundary && LOAD_REQ;
      if (boundary) begin
        m_bright = BRIGHT;
        m_blz    = BLANK_LZ;
        if (LOAD_REQ) m_disp = DATA_IN;
      end
      if (m_c == SLOT - 1) begin
        m_c = 0;
        m_d = (m_d + 1) % 4;
      end else begin
        m_c = m_c + 1;
      end
    end
  endtask

  // One clock: predict, clock, compare all outputs against the prediction.
  task automatic tick();
    logic [11:0] got;
    logic [11:0] exp;
    logic        was_rst;
    was_rst = RST;
    model_step();
    exp_q.push_back(model_out());
    @(posedge CLK);
    #1;
    cyc = was_rst ? 0 : cyc + 1;
    got = {COMM, DIGIT_SEL, NIBBLE, FRAME_START, LOAD_ACK};
    if (exp_q.size() == 0) begin
      check("queue_empty", 16'(exp_q.size()), 16'd1);
    end else begin
      exp = exp_q.pop_front();
      check("cycle", 16'(got), 16'(exp));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  logic [15:0] mask;

  initial begin
    // 1: basic scan timing, full brightness
    BRIGHT = 4'hF; BLANK_LZ = 1'b0; LOAD_REQ = 1'b0;
    do_reset();
    check("s1_fs0", 16'(FRAME_START), 16'd1);
    check("s1_sel0", 16'(DIGIT_SEL), 16'd0);
    check("s1_comm0", 16'(COMM), 16'h0);
    run_to(7);   check("s1_dead7", 16'(COMM), 16'h0);
    run_to(8);   check("s1_comm8", 16'(COMM), 16'h1); check("s1_nib8", 16'(NIBBLE), 16'h4);
    run_to(39);  check("s1_comm39", 16'(COMM), 16'h1);
    run_to(40);  check("s1_comm40", 16'(COMM), 16'h0); check("s1_sel40", 16'(DIGIT_SEL), 16'd1);
    run_to(48);  check("s1_comm48", 16'(COMM), 16'h2); check("s1_nib48", 16'(NIBBLE), 16'h3);
    run_to(128); check("s1_comm128", 16'(COMM), 16'h8); check("s1_nib128", 16'(NIBBLE), 16'h1);
    run_to(159); check("s1_fs159", 16'(FRAME_START), 16'd0);
    run_to(160); check("s1_fs160", 16'(FRAME_START), 16'd1);

    // 2: BRIGHT=3 latched at the first boundary
    BRIGHT = 4'd3;
    do_reset();
    run_to(168); check("s2_168", 16'(COMM), 16'h1);
    run_to(171); check("s2_171", 16'(COMM), 16'h1);
    run_to(172); check("s2_172", 16'(COMM), 16'h0);
    run_to(183); check("s2_183", 16'(COMM), 16'h0);
    run_to(184); check("s2_184", 16'(COMM), 16'h1);
    run_to(188); check("s2_188", 16'(COMM), 16'h0);

    // 3: load handshake takes effect only at the frame boundary
    BRIGHT = 4'hF; DATA_IN = 16'hABCD;
    do_reset();
    run_to(50);  LOAD_REQ = 1'b1;
    run_to(159); check("s3_nib159", 16'(NIBBLE), 16'h1); check("s3_ack159", 16'(LOAD_ACK), 16'd0);
    run_to(160); check("s3_nib160", 16'(NIBBLE), 16'hD); check("s3_ack160", 16'(LOAD_ACK), 16'd1);
    run_to(161); check("s3_ack161", 16'(LOAD_ACK), 16'd0); LOAD_REQ = 1'b0;
    run_to(320); check("s3_ack320", 16'(LOAD_ACK), 16'd0); check("s3_nib320", 16'(NIBBLE), 16'hD);

    // 4: leading-zero blanking
    BLANK_LZ = 1'b1; DATA_IN = 16'h0042; LOAD_REQ = 1'b1;
    do_reset();
    run_to(160); LOAD_REQ = 1'b0;
    run_to(168); check("s4_d0", 16'(COMM), 16'h1); check("s4_n0", 16'(NIBBLE), 16'h2);
    run_to(208); check("s4_d1", 16'(COMM), 16'h2); check("s4_n1", 16'(NIBBLE), 16'h4);
    run_to(248); check("s4_d2", 16'(COMM), 16'h0);
    run_to(288); check("s4_d3", 16'(COMM), 16'h0);
    DATA_IN = 16'h0000;
    run_to(300); LOAD_REQ = 1'b1;
    run_to(320); check("s4_ack", 16'(LOAD_ACK), 16'd1); LOAD_REQ = 1'b0;
    run_to(328); check("s4z_d0", 16'(COMM), 16'h1); check("s4z_n0", 16'(NIBBLE), 16'h0);
    run_to(368); check("s4z_d1", 16'(COMM), 16'h0);
    run_to(408); check("s4z_d2", 16'(COMM), 16'h0);
    run_to(448); check("s4z_d3", 16'(COMM), 16'h0);

    // 5: reset mid-frame with a request pending
    BLANK_LZ = 1'b0; DATA_IN = 16'h5678;
    do_reset();
    run_to(90);  LOAD_REQ = 1'b1;
    run_to(100);
    RST = 1'b1; tick(); RST = 1'b0;
    check("s5_sel", 16'(DIGIT_SEL), 16'd0);
    check("s5_comm", 16'(COMM), 16'h0);
    check("s5_fs", 16'(FRAME_START), 16'd1);
    check("s5_nib", 16'(NIBBLE), 16'h4);
    tick();
    while (!LOAD_ACK && cyc < 400) tick();
    check("s5_ack_cyc", 16'(cyc), 16'd160);
    check("s5_nib_new", 16'(NIBBLE), 16'h8);
    LOAD_REQ = 1'b0;

    // reset coinciding with the frame boundary: no capture, no ack
    do_reset();
    LOAD_REQ = 1'b1; DATA_IN = 16'h9999;
    run_to(159);
    RST = 1'b1; tick(); RST = 1'b0;
    check("rb_ack", 16'(LOAD_ACK), 16'd0);
    check("rb_nib", 16'(NIBBLE), 16'h4);
    LOAD_REQ = 1'b0;

    // 6: brightness change mid-frame applies at the next boundary
    BRIGHT = 4'hF;
    do_reset();
    run_to(170); BRIGHT = 4'd0;
    run_to(190); check("s6_190", 16'(COMM), 16'h1);
    run_to(319); check("s6_319", 16'(COMM), 16'h8);
    run_to(328); check("s6_328", 16'(COMM), 16'h1);
    run_to(329); check("s6_329", 16'(COMM), 16'h0);
    run_to(343); check("s6_343", 16'(COMM), 16'h0);
    run_to(344); check("s6_344", 16'(COMM), 16'h1);

    // random settings, model checks every cycle
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      if (i % 8 == 0) begin
        case ($urandom_range(0, 3))
          0:       mask = 16'hFFFF;
          1:       mask = 16'h00FF;
          2:       mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        DATA_IN  = 16'($urandom) & mask;
        LOAD_REQ = 1'($urandom_range(0, 1));
        BRIGHT   = 4'($urandom_range(0, 15));
        BLANK_LZ = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
